alu_input_sequencer: RTL
========================

# alu_input_sequencer

Operand/op-code sequencer directly upstream of the 8-bit arithmetic-logic unit. It loads operand A, operand B and the 4-bit ALU control code one after another from a single shared input bus, one `load` strobe each. It drives them to the combinational ALU, then registers the ALU result and flags one cycle later. The captured result and flags feed the downstream output register and display stage.

## Interface
- `N`, 8, operand/result width
- `OPW`, 4, ALU control code width (taken from `din[OPW-1:0]`)
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `din`  in  N  shared data bus (switches): operand A, operand B, op-code in turn
- `load`  in  1  single-cycle strobe (already debounced/edge-detected upstream)
- `clear`  in  1  synchronous abort, returns to start
- `alu_result`  in  N  combinational ALU result
- `alu_flags`  in  4  ALU flags {negative, zero, overflow, carry}
- `operand_a`  out  N  registered operand A to ALU
- `operand_b`  out  N  registered operand B to ALU
- `alu_control`  out  OPW  registered op-code to ALU
- `result_q`  out  N  captured ALU result
- `flags_q`  out  4  captured flags, same bit order as `alu_flags`
- `done`  out  1  high while `result_q`/`flags_q` hold a fresh capture
- `stage`  out  3  current state encoding, for LED display

## Operation
- States and `stage` codes: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Codes 5–7 are unused and recover to LOAD_A on the next edge.
- LOAD_A + `load`: `operand_a`<=`din`, `done`<=0, go to LOAD_B.
- LOAD_B + `load`: `operand_b`<=`din`, go to LOAD_OP.
- LOAD_OP + `load`: `alu_control`<=`din[OPW-1:0]`, go to EXEC. Upper `din` bits are ignored.
- EXEC: unconditional. `result_q`<=`alu_result`, `flags_q`<=`alu_flags`, `done`<=1, go to SHOW. `load` is ignored in this cycle.
- SHOW + `load`: acts as LOAD_A. `operand_a`<=`din`, `done`<=0, go to LOAD_B. `result_q`/`flags_q` keep their old value until the next EXEC.
- Without `load`, every state holds and all registers hold.
- `operand_a`, `operand_b` and `alu_control` stay stable from their load until overwritten. The ALU output therefore stays stable through SHOW.
- `clear` (sync, any state): all output registers go to their reset values and the state goes to LOAD_A. `clear` wins over a simultaneous `load`.
- No arithmetic is performed here. Widths pass through unchanged, with no sign or zero extension.

## Timing
- Reset (`reset`=0, asynchronous, takes effect immediately without a clock): state LOAD_A, `stage`=0, `operand_a`=0, `operand_b`=0, `alu_control`=0, `result_q`=0, `flags_q`=0, `done`=0.
- Reset release: registers update from the first rising edge with `reset`=1.
- Every `load` is sampled on the rising edge; the loaded value is visible right after that edge.
- Latency: op-code loaded at edge k. `alu_control` is valid during cycle k→k+1, and the ALU settles within that cycle. `result_q`, `flags_q` and `done`=1 are valid after edge k+1.
- `load` held high for several cycles advances one state per cycle, except in EXEC. Upstream guarantees single-cycle strobes.
- Reset asserted mid-sequence discards the partial operands, with no partial capture.

## Test plan
- Reset, then release. All outputs are 0 and `stage`=0. Assert reset asynchronously mid-cycle while in LOAD_OP: outputs clear before the next edge.
- Full sequence:
  - Strobes: `din`=8'hB5 (A), `din`=8'hAB (B), `din`=8'h03 (op).
  - Bench ALU model drives `alu_result`=8'h60, `alu_flags`=4'b0011 while `alu_control`=4'h3.
  - Required: `operand_a`=8'hB5, `operand_b`=8'hAB, `alu_control`=4'h3. One edge after the op load: `result_q`=8'h60, `flags_q`=4'b0011, `done`=1, `stage`=4.
- `load` held high 4 cycles from LOAD_A with `din`=8'h07:
  - stage sequence 0→1→2→3→4.
  - EXEC ignores `load`.
  - Capture happens exactly once.
- `clear` and `load` asserted together in LOAD_B: state goes to LOAD_A, all registers go to 0, and `operand_b` is not loaded.
- New sequence from SHOW (after the 8'h60 capture), `din`=8'h10:
  - Required: `operand_a`=8'h10, `done`=0, `stage`=1.
  - `result_q` stays 8'h60 until the next EXEC.
- `din`=8'hF5 in LOAD_OP: `alu_control`=4'h5, upper bits ignored.

Source files
------------

// File: rtl/alu_input_sequencer_if.sv
// Bus bundle between the switch/strobe front end, the sequencer and the ALU.
// The slave side is the sequencer itself; the master side is its environment.
interface alu_input_sequencer_if #(
    parameter int N   = 8,
    parameter int OPW = 4
);
    logic [N-1:0]   din;
    logic           load;
    logic           clear;
    logic [N-1:0]   alu_result;
    logic [3:0]     alu_flags;
    logic [N-1:0]   operand_a;
    logic [N-1:0]   operand_b;
    logic [OPW-1:0] alu_control;
    logic [N-1:0]   result_q;
    logic [3:0]     flags_q;
    logic           done;
    logic [2:0]     stage;

    modport master (
        output din, load, clear, alu_result, alu_flags,
        input  operand_a, operand_b, alu_control, result_q, flags_q, done, stage
    );

    modport slave (
        input  din, load, clear, alu_result, alu_flags,
        output operand_a, operand_b, alu_control, result_q, flags_q, done, stage
    );
endinterface

// File: rtl/alu_input_sequencer.sv
// Loads operand A, operand B and the op-code from one shared bus, one strobe each,
// then captures the combinational ALU result and flags one cycle later.
module alu_input_sequencer #(
    parameter int N   = 8,
    parameter int OPW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_input_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           ld_a;
    logic           ld_b;
    logic           ld_op;
    logic           capture;

    logic [N-1:0]   operand_a_q;
    logic [N-1:0]   operand_b_q;
    logic [OPW-1:0] alu_control_q;
    logic [N-1:0]   result_r;
    logic [3:0]     flags_r;
    logic           done_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_op      = 1'b0;
        capture    = 1'b0;
        if (bus.clear) begin
            state_next = LOAD_A;
        end else begin
            case (state)
                LOAD_A, SHOW: begin
                    if (bus.load) begin
                        ld_a       = 1'b1;
                        state_next = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (bus.load) begin
                        ld_b       = 1'b1;
                        state_next = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (bus.load) begin
                        ld_op      = 1'b1;
                        state_next = EXEC;
                    end
                end
                EXEC: begin
                    capture    = 1'b1;
                    state_next = SHOW;
                end
                default: state_next = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            alu_control_q <= '0;
            result_r      <= '0;
            flags_r       <= '0;
            done_r        <= 1'b0;
        end else if (bus.clear) begin
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            alu_control_q <= '0;
            result_r      <= '0;
            flags_r       <= '0;
            done_r        <= 1'b0;
        end else begin
            if (ld_a) begin
                operand_a_q <= bus.din;
                done_r      <= 1'b0;
            end
            if (ld_b) begin
                operand_b_q <= bus.din;
            end
            if (ld_op) begin
                alu_control_q <= bus.din[OPW-1:0];
            end
            // Result and flags persist through the next sequence until the following EXEC.
            if (capture) begin
                result_r <= bus.alu_result;
                flags_r  <= bus.alu_flags;
                done_r   <= 1'b1;
            end
        end
    end

    assign bus.operand_a   = operand_a_q;
    assign bus.operand_b   = operand_b_q;
    assign bus.alu_control = alu_control_q;
    assign bus.result_q    = result_r;
    assign bus.flags_q     = flags_r;
    assign bus.done        = done_r;
    assign bus.stage       = state;

endmodule
